// File: rtl/midi_pkg.sv
// Shared MIDI definitions: default baud, status-byte masks and the serial FSM
// state encoding used by both the transmitter and the receiver.
package midi_pkg;

    localparam int MIDI_BAUD_DEF = 31250;

    localparam logic [7:0] STATUS_MASK  = 8'h80;
    localparam logic [7:0] SYSTEM_MASK  = 8'hF0;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } midi_state_t;

    // Channel voice/mode status: 0x80..0xEF
    function automatic logic is_channel_status(input logic [7:0] b);
        return ((b & STATUS_MASK) != 8'h00) && ((b & SYSTEM_MASK) != SYSTEM_MASK);
    endfunction

    // System common: 0xF0..0xF7
    function automatic logic is_system_common(input logic [7:0] b);
        return ((b & SYSTEM_MASK) == SYSTEM_MASK) && (b < REALTIME_MIN);
    endfunction

endpackage

// File: rtl/single_midi_out_if.sv
// Byte handshake between a MIDI byte producer (master) and the serial
// transmitter (slave).
interface single_midi_out_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] data_tx;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output data_tx, output tx_valid, input tx_ready);
    modport slave  (input data_tx, input tx_valid, output tx_ready);
endinterface

// File: rtl/midi_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 unless cleared. o_tick marks the
// last clock of a bit, o_pre_tick the clock before it. Needs CLKS_PER_BIT >= 2.
module midi_baud_tick #(
    parameter int CLKS_PER_BIT = 1600
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick     = (r_cnt == LAST);
    assign o_pre_tick = (r_cnt == PRE);
endmodule

// File: rtl/single_midi_out.sv
// MIDI 8N1 serial transmitter, one byte per valid/ready handshake, LSB first.
// Define MIDI_TX_RUNNING_STATUS_EN to drop repeated channel status bytes.
module single_midi_out
    import midi_pkg::*;
#(
    parameter int SYSCLK_F     = 50000000,
    parameter int MIDI_BAUD    = MIDI_BAUD_DEF,
    parameter int BYTE_W       = 8,
    parameter int CLKS_PER_BIT = SYSCLK_F / MIDI_BAUD
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    single_midi_out_if.slave         tx_if,
    output logic                     MIDI_OUT,
    output logic                     busy,
    output logic                     byte_done_strobe
);
    midi_state_t       r_state;
    logic [BYTE_W-1:0] r_shift;
    logic [2:0]        r_bit_cnt;
    logic              r_line;
    logic              r_ready;
    logic              r_busy;
    logic              r_strobe;

    logic w_hs;
    logic w_skip;
    logic w_tick;
    logic w_pre_tick;

    assign w_hs = tx_if.tx_valid && r_ready;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [BYTE_W-1:0] r_rs;

    // r_rs only ever holds a channel status byte, so bit 7 means "valid"
    assign w_skip = r_rs[7] && (tx_if.data_tx == r_rs);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rs <= '0;
        end else if (w_hs) begin
            if (is_channel_status(tx_if.data_tx)) begin
                r_rs <= tx_if.data_tx;
            end else if (is_system_common(tx_if.data_tx)) begin
                r_rs <= '0;
            end
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    midi_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (sys_clk),
        .rst       (rst),
        .i_clear   (r_state == IDLE),
        .o_tick    (w_tick),
        .o_pre_tick(w_pre_tick)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_line    <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        if (w_skip) begin
                            r_strobe <= 1'b1;
                        end else begin
                            r_state   <= START;
                            r_shift   <= tx_if.data_tx;
                            r_bit_cnt <= '0;
                            r_line    <= 1'b0;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_line  <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                            r_line  <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_line    <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    // Strobe is registered one clock early so it lands on the last stop clock
                    if (w_pre_tick) begin
                        r_strobe <= 1'b1;
                    end
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.tx_ready   = r_ready;
    assign MIDI_OUT         = r_line;
    assign busy             = r_busy;
    assign byte_done_strobe = r_strobe;
endmodule

// File: tb/tb_single_midi_out.sv
// Self-checking bench for single_midi_out: cycle-level behavioural model of the
// line plus an independent UART decoder, directed and random byte streams.
module tb_single_midi_out;
    localparam int SYSCLK_F = 500000;
    localparam int BAUD     = 31250;
    localparam int C        = SYSCLK_F / BAUD;
    localparam int FRAME    = 10 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic midi_out;
    logic busy;
    logic strobe;

    single_midi_out_if #(.BYTE_W(8)) ifc ();

    single_midi_out #(
        .SYSCLK_F (SYSCLK_F),
        .MIDI_BAUD(BAUD),
        .BYTE_W   (8)
    ) dut (
        .sys_clk         (clk),
        .rst             (rst),
        .tx_if           (ifc),
        .MIDI_OUT        (midi_out),
        .busy            (busy),
        .byte_done_strobe(strobe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: frame in flight and the number of clocks since its handshake
    bit         m_active = 0;
    int         m_k = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_rs = 8'h00;
    bit         m_cons = 0;
    logic [7:0] sent_q[$];

    logic [7:0] rx_q[$];
    logic [9:0] rx_bits = '0;
    bit         rx_on = 0;
    int         rx_cnt = 0;
    logic       rx_prev = 1'b1;

    int cyc = 0;
    int first_acc = -1;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;

    function automatic logic exp_line(input logic [7:0] b, input int k);
        int n;
        n = k / C;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_active = 0;
                m_k      = 0;
                m_rs     = 8'h00;
                m_cons   = 0;
                rx_on    = 0;
            end
            check("MIDI_OUT", midi_out, m_active ? exp_line(m_byte, m_k) : 1'b1);
            check("busy", busy, m_active);
            check("tx_ready", ifc.tx_ready, !m_active);
            check("byte_done_strobe", strobe, (m_active && m_k == FRAME - 1) || m_cons);
            if (strobe === 1'b1) begin
                strobe_cnt++;
                last_strobe_cyc = cyc;
            end

            if (!rst) begin
                if (!rx_on) begin
                    if (midi_out == 1'b0 && rx_prev == 1'b1) begin
                        rx_on  = 1;
                        rx_cnt = 0;
                    end
                end else begin
                    rx_cnt++;
                end
                if (rx_on && rx_cnt >= C / 2 && ((rx_cnt - C / 2) % C) == 0) begin
                    rx_bits[(rx_cnt - C / 2) / C] = midi_out;
                    if ((rx_cnt - C / 2) / C == 9) begin
                        rx_q.push_back(rx_bits[8:1]);
                        rx_on = 0;
                    end
                end
            end
            rx_prev = midi_out;

            // Predict the effect of the coming rising edge
            if (!rst) begin
                m_cons = 0;
                if (m_active) begin
                    m_k++;
                    if (m_k == FRAME) m_active = 0;
                end else if (ifc.tx_valid) begin
                    if (first_acc < 0) first_acc = cyc;
`ifdef MIDI_TX_RUNNING_STATUS_EN
                    if (m_rs != 8'h00 && ifc.data_tx == m_rs) begin
                        m_cons = 1;
                    end else begin
                        m_active = 1; m_k = 0; m_byte = ifc.data_tx; sent_q.push_back(ifc.data_tx);
                    end
                    if (ifc.data_tx >= 8'h80 && ifc.data_tx <= 8'hEF) m_rs = ifc.data_tx;
                    else if (ifc.data_tx >= 8'hF0 && ifc.data_tx <= 8'hF7) m_rs = 8'h00;
`else
                    m_active = 1; m_k = 0; m_byte = ifc.data_tx; sent_q.push_back(ifc.data_tx);
`endif
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (ifc.tx_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("tx_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        ifc.data_tx  = b;
        ifc.tx_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        ifc.tx_valid = 1'b0;
        ifc.data_tx  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || rx_on) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("idle_timeout", 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) check(name, 32'hDEAD, exp);
        else check(name, rx_q.pop_front(), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b2b[3];
        int s0;
        ifc.tx_valid = 1'b0;
        ifc.data_tx  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (200) @(negedge clk);
        check("idle_line", midi_out, 1'b1);
        check("idle_ready", ifc.tx_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Single 0xC9 frame
        first_acc = -1; s0 = strobe_cnt; rx_q.delete();
        send(8'hC9);
        wait_idle();
        check("c9_strobe_clock", last_strobe_cyc - first_acc, 160);
        check("c9_strobe_count", strobe_cnt - s0, 1);
        check("c9_line_bits", rx_bits, 10'b1110010010);
        check_rx("c9_byte", 8'hC9);

        // tx_valid held high across three bytes
        b2b = '{8'h90, 8'h3C, 8'h7F};
        first_acc = -1; s0 = strobe_cnt; rx_q.delete();
        @(posedge clk); #1;
        ifc.data_tx = b2b[0]; ifc.tx_valid = 1'b1;
        for (int i = 1; i < 3; i++) begin
            wait_ready();
            @(posedge clk); #1;
            ifc.data_tx = b2b[i];
        end
        wait_ready();
        @(posedge clk); #1;
        ifc.tx_valid = 1'b0;
        wait_idle();
        check("b2b_strobe_count", strobe_cnt - s0, 3);
        check("b2b_span", last_strobe_cyc - first_acc, 482);
        for (int i = 0; i < 3; i++) check_rx("b2b_byte", b2b[i]);

        // Reset in mid-frame
        s0 = strobe_cnt; rx_q.delete();
        send(8'h55);
        repeat (80) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_line_high", midi_out, 1'b1);
        check("rst_busy_low", busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (200) @(negedge clk);
        check("rst_no_strobe", strobe_cnt - s0, 0);
        check("rst_no_byte", rx_q.size(), 0);
        send(8'hA5);
        wait_idle();
        check_rx("post_rst_byte", 8'hA5);

        // Valid with changing data while busy is ignored
        rx_q.delete();
        send(8'h3C);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            ifc.tx_valid = 1'b1;
            ifc.data_tx  = 8'($urandom);
        end
        @(posedge clk); #1 ifc.tx_valid = 1'b0;
        wait_idle();
        check_rx("busy_ignore_byte", 8'h3C);
        check("busy_ignore_count", rx_q.size(), 0);

        // Random stream against the model's transmitted list
        sent_q.delete(); rx_q.delete();
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send(8'($urandom));
        end
        wait_idle();
        check("rand_count", rx_q.size(), sent_q.size());
        while (rx_q.size() > 0 && sent_q.size() > 0) check("rand_byte", rx_q.pop_front(), sent_q.pop_front());

`ifdef MIDI_TX_RUNNING_STATUS_EN
        begin
            logic [7:0] rs_in[8];
            logic [7:0] rs_out[6];
            rs_in  = '{8'h90, 8'h3C, 8'h90, 8'h40, 8'hF8, 8'h90, 8'hF2, 8'h90};
            rs_out = '{8'h90, 8'h3C, 8'h40, 8'hF8, 8'hF2, 8'h90};
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            s0 = strobe_cnt; rx_q.delete();
            for (int i = 0; i < 8; i++) send(rs_in[i]);
            wait_idle();
            check("rs_strobe_count", strobe_cnt - s0, 8);
            check("rs_count", rx_q.size(), 6);
            for (int i = 0; i < 6; i++) check_rx("rs_byte", rs_out[i]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/single_midi_out.md
Name: single_midi_out

Overview:
- MIDI 8N1 serial transmitter; the transmit-side counterpart of single_midi_in. The two share the same sys_clk domain and the same SYSCLK_F/baud parameters.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first on MIDI_OUT: start bit, 8 data bits, stop bit.
- Idle line is high. Intended to drive the UART-style MIDI OUT buffer. It is also the stimulus source for single_midi_in loopback tests.

Parameters:
- SYSCLK_F, 50000000, system clock frequency in Hz.
- MIDI_BAUD, 31250, line bit rate in baud.
- BYTE_W, 8, data width; fixed at 8 for MIDI; other values unsupported.
- CLKS_PER_BIT, SYSCLK_F / MIDI_BAUD, derived bit period in clocks (1600 at defaults = 32 us); integer division, truncating.

Ports:
- sys_clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_tx  input  BYTE_W  byte to send; sampled only on handshake.
- tx_valid  input  1  data_tx is valid.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- MIDI_OUT  output  1  serial line; idle high.
- busy  output  1  frame in progress (any state other than IDLE).
- byte_done_strobe  output  1  single-cycle pulse on the last clock of the stop bit.

Behaviour:
- Reset values (asynchronous): MIDI_OUT=1, tx_ready=1, busy=0, byte_done_strobe=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- tx_ready is high exactly when state is IDLE.
- Handshake occurs when tx_valid and tx_ready are both high at a rising edge. On that edge data_tx is latched into the shift register and the FSM enters START.
- Data changes while not ready are ignored; there is no buffering beyond the shift register.
- Latency: MIDI_OUT drives low on the same edge as the handshake, so it is low from cycle N+1 onward.
- FSM:
  - IDLE -> START on handshake.
  - START: MIDI_OUT=0 for CLKS_PER_BIT clocks -> DATA.
  - DATA: MIDI_OUT=shift[0], held CLKS_PER_BIT clocks per bit, then shift right. After bit 7 -> STOP.
  - STOP: MIDI_OUT=1 for CLKS_PER_BIT clocks. byte_done_strobe=1 on the final clock of STOP -> IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. It reloads to 0 on every bit boundary and on handshake. Its width is clog2(CLKS_PER_BIT).
- Bit counter: counts 0..7, 3 bits wide; wrap-around is not used.
- Frame length is exactly 10*CLKS_PER_BIT clocks (16000 at defaults).
- Back-to-back: tx_ready rises the cycle after byte_done_strobe. A byte presented then starts its START bit with zero idle gap beyond one clock.
- tx_valid held high continuously: every byte is sent consecutively; no bytes are dropped or duplicated.
- Reset mid-frame: the line returns high immediately and the partial frame is abandoned. No strobe is issued.

Optional Feature:
- Macro: MIDI_TX_RUNNING_STATUS_EN.
- Defined:
  - A running-status register (reset 0x00 = none) holds the last transmitted channel status byte (0x80-0xEF).
  - An accepted byte equal to the running status is consumed but not transmitted. tx_ready stays high, no frame is sent, and byte_done_strobe pulses for one cycle on the next clock.
  - A new channel status byte is sent and updates the register.
  - System common bytes 0xF0-0xF7 are sent and clear the register.
  - Realtime bytes 0xF8-0xFF are sent and leave the register unchanged.
  - Data bytes (0x00-0x7F) are always sent.
- Undefined: every accepted byte is transmitted verbatim and no running-status logic exists.

Decomposition:
- Shared package midi_pkg contains:
  - MIDI_BAUD default.
  - Status/data masks: bit 7 = status, 0xF0 = system, 0xF8 = realtime threshold.
  - FSM state encoding (IDLE, START, DATA, STOP), shared with single_midi_in.
- One sub-module, midi_baud_tick:
  - Parameterised bit-period counter with a clear input and a single-cycle tick output.
  - Reusable by the receiver.

Test Plan:
- Reset, then idle 1 ms -> MIDI_OUT=1, tx_ready=1, busy=0 throughout.
- Send 0xC9 at defaults (50 MHz) -> MIDI_OUT low for 1600 clocks, then bits 1,0,0,1,0,0,1,1 at 1600 clocks each, then high 1600 clocks. byte_done_strobe at clock 16000. A loopback single_midi_in reports data_rx=0xC9, is_command=1.
- tx_valid held high with 0x90, 0x3C, 0x7F -> three contiguous frames in 48000 (+2) clocks. Three strobes, correct order.
- Assert rst at clock 5000 of a frame -> MIDI_OUT=1 within the same cycle, busy=0, no strobe. The next byte transmits correctly.
- tx_valid asserted while busy with a changing data_tx -> ignored; tx_ready=0 until the frame ends.
- With MIDI_TX_RUNNING_STATUS_EN, send 0x90, 0x3C, 0x90, 0x40, 0xF8, 0x90 -> line carries 0x90, 0x3C, 0x40, 0xF8 only. Then send 0xF2 followed by 0x90 -> both transmitted.
